// File: rtl/vga_draw_scheduler_pkg.sv
// vga_draw_scheduler_pkg: plotter opcodes, scheduler states and grant helpers
package vga_draw_scheduler_pkg;
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT} state_t;
  localparam logic [3:0] OP_NONE       = 4'd0;
  localparam logic [3:0] OP_CLEAR      = 4'd1;
  localparam logic [3:0] OP_VOL_ON     = 4'd2;
  localparam logic [3:0] OP_VOL_OFF    = 4'd3;
  localparam logic [3:0] OP_DIST_ON    = 4'd4;
  localparam logic [3:0] OP_DIST_OFF   = 4'd5;
  localparam logic [3:0] OP_PITCH_ON   = 4'd6;
  localparam logic [3:0] OP_PITCH_OFF  = 4'd7;
  localparam logic [3:0] OP_DRAW_VOL   = 4'd9;
  localparam logic [3:0] OP_DRAW_PITCH = 4'd10;
  localparam logic [3:0] OP_DRAW_DIST  = 4'd11;
  // effect index: 0 volume, 1 pitch, 2 distortion
  function automatic logic [3:0] toggle_op(input logic [1:0] idx, input logic on);
    return idx == 2'd0 ? (on ? OP_VOL_ON : OP_VOL_OFF) :
           idx == 2'd1 ? (on ? OP_PITCH_ON : OP_PITCH_OFF) :
                         (on ? OP_DIST_ON : OP_DIST_OFF);
  endfunction
  function automatic logic [3:0] level_op(input logic [1:0] idx);
    return idx == 2'd0 ? OP_DRAW_VOL : idx == 2'd1 ? OP_DRAW_PITCH : OP_DRAW_DIST;
  endfunction
  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    return oh[1] ? 2'd1 : oh[2] ? 2'd2 : 2'd0;
  endfunction
endpackage

// File: rtl/vga_draw_scheduler_rr_arbiter3.sv
// rr_arbiter3: three-request round-robin arbiter, one-hot grant, pointer moves past the winner on advance
module rr_arbiter3 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] gnt
);
  logic [1:0] ptr;
  logic p0, p1, p2;
  // search order starts at ptr and wraps: 0,1,2 / 1,2,0 / 2,0,1
  always_comb begin
    p0 = ptr == 2'd0;
    p1 = ptr == 2'd1;
    p2 = ptr == 2'd2;
    gnt[0] = req[0] & (p0 | (p1 & ~req[1] & ~req[2]) | (p2 & ~req[2]));
    gnt[1] = req[1] & ((p0 & ~req[0]) | p1 | (p2 & ~req[2] & ~req[0]));
    gnt[2] = req[2] & ((p0 & ~req[0] & ~req[1]) | (p1 & ~req[1]) | p2);
  end
  // pointer lands on the effect after the one just served
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) ptr <= 2'd0;
    else if (advance && |gnt) ptr <= gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : 2'd0;
  end
endmodule

// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: coalesces effect UI events and issues one plotter command at a time
module vga_draw_scheduler
  import vga_draw_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DATA_W         = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              VolumeTurnedOn,
  input  logic              VolumeTurnedOff,
  input  logic              PitchTurnedOn,
  input  logic              PitchTurnedOff,
  input  logic              DistortionTurnedOn,
  input  logic              DistortionTurnedOff,
  input  logic              VolumeGo,
  input  logic              PitchGo,
  input  logic              DistortionGo,
  input  logic [DATA_W-1:0] volume_data,
  input  logic [DATA_W-1:0] pitch_data,
  input  logic [DATA_W-1:0] distortion_data,
  input  logic              PlotReady,
  input  logic              PlotDone,
  output logic              PlotStart,
  output logic [3:0]        PlotOp,
  output logic [DATA_W-1:0] PlotData,
  output logic              Busy,
  output logic              Timeout
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  state_t state, state_nxt;
  logic [2:0] on, off, go;
  logic [DATA_W-1:0] go_data [3];
  logic [2:0] tog_pend, tog_val, lvl_pend;
  logic [DATA_W-1:0] lvl [3];
  logic [WD_W-1:0] wd;
  logic [2:0] tog_gnt, lvl_gnt, tog_clr, lvl_clr;
  logic any_tog, grant, wd_term, timeout_hit;
  logic [1:0] gidx;
  logic [3:0] grant_op;
  logic [DATA_W-1:0] grant_data;
  assign on  = {DistortionTurnedOn, PitchTurnedOn, VolumeTurnedOn};
  assign off = {DistortionTurnedOff, PitchTurnedOff, VolumeTurnedOff};
  assign go  = {DistortionGo, PitchGo, VolumeGo};
  assign go_data[0] = volume_data;
  assign go_data[1] = pitch_data;
  assign go_data[2] = distortion_data;
  rr_arbiter3 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    (lvl_pend),
    .advance(grant && !any_tog),
    .gnt    (lvl_gnt)
  );
  // grant selection: lowest-index toggle first, otherwise the round-robin level winner
  always_comb begin
    any_tog    = |tog_pend;
    tog_gnt    = tog_pend & (~tog_pend + 3'd1);
    grant      = state == S_IDLE && PlotReady && (any_tog || |lvl_pend);
    tog_clr    = grant && any_tog ? tog_gnt : 3'b000;
    lvl_clr    = grant && !any_tog ? lvl_gnt : 3'b000;
    gidx       = onehot_idx(any_tog ? tog_gnt : lvl_gnt);
    grant_op   = any_tog ? toggle_op(gidx, tog_val[gidx]) : level_op(gidx);
    grant_data = any_tog ? '0 : lvl[gidx];
    wd_term    = wd == WD_W'(TIMEOUT_CYCLES - 1);
  end
  // state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_INIT;
    else state <= state_nxt;
  end
  // next state and state-decoded outputs
  always_comb begin
    state_nxt   = state;
    PlotStart   = state == S_ISSUE;
    Busy        = state != S_IDLE;
    timeout_hit = state == S_WAIT && wd_term && !PlotDone;
    unique case (state)
      S_INIT:  state_nxt = PlotReady ? S_ISSUE : S_INIT;
      S_IDLE:  state_nxt = grant ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = PlotDone || wd_term ? S_IDLE : S_WAIT;
      default: state_nxt = S_INIT;
    endcase
  end
  // command snapshot: held until the next grant so later Go pulses cannot disturb it
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      PlotOp   <= OP_NONE;
      PlotData <= '0;
    end else if (state == S_INIT && PlotReady) begin
      PlotOp   <= OP_CLEAR;
      PlotData <= '0;
    end else if (grant) begin
      PlotOp   <= grant_op;
      PlotData <= grant_data;
    end
  end
  // watchdog: restarts on entry to WAIT, saturates, sticky flag on abort
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wd      <= '0;
      Timeout <= 1'b0;
    end else begin
      if (state == S_ISSUE) wd <= '0;
      else if (state == S_WAIT && wd != '1) wd <= wd + 1'b1;
      if (timeout_hit) Timeout <= 1'b1;
    end
  end
  // pending set: new pulses win over a same-cycle grant clear, Off wins over On
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tog_pend <= '0;
      tog_val  <= '0;
      lvl_pend <= '0;
      for (int i = 0; i < 3; i++) lvl[i] <= '0;
    end else begin
      tog_pend <= on | off | (tog_pend & ~tog_clr);
      lvl_pend <= go | (lvl_pend & ~lvl_clr);
      for (int i = 0; i < 3; i++) begin
        if (on[i] || off[i]) tog_val[i] <= ~off[i];
        if (go[i]) lvl[i] <= go_data[i];
      end
    end
  end
endmodule

// File: tb/tb_vga_draw_scheduler.sv
// tb_vga_draw_scheduler: scoreboard bench for the draw scheduler
module tb_vga_draw_scheduler;
  localparam int TO = 4096;
  typedef struct { logic [3:0] op; logic [6:0] data; } exp_t;
  logic Clock = 1'b0;
  logic Reset;
  logic VolumeTurnedOn, VolumeTurnedOff, PitchTurnedOn, PitchTurnedOff;
  logic DistortionTurnedOn, DistortionTurnedOff, VolumeGo, PitchGo, DistortionGo;
  logic [6:0] volume_data, pitch_data, distortion_data;
  logic PlotReady, PlotDone, PlotStart, Busy, Timeout;
  logic [3:0] PlotOp;
  logic [6:0] PlotData;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_pass = 0;

  vga_draw_scheduler #(.TIMEOUT_CYCLES(TO), .DATA_W(7)) dut (
    .Clock(Clock), .Reset(Reset),
    .VolumeTurnedOn(VolumeTurnedOn), .VolumeTurnedOff(VolumeTurnedOff),
    .PitchTurnedOn(PitchTurnedOn), .PitchTurnedOff(PitchTurnedOff),
    .DistortionTurnedOn(DistortionTurnedOn), .DistortionTurnedOff(DistortionTurnedOff),
    .VolumeGo(VolumeGo), .PitchGo(PitchGo), .DistortionGo(DistortionGo),
    .volume_data(volume_data), .pitch_data(pitch_data), .distortion_data(distortion_data),
    .PlotReady(PlotReady), .PlotDone(PlotDone), .PlotStart(PlotStart),
    .PlotOp(PlotOp), .PlotData(PlotData), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  // every command strobe pops the scoreboard
  always @(negedge Clock) begin
    if (Reset === 1'b1 && PlotStart === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) $display("FAIL cmd: unexpected PlotStart op=%0d data=%0d", PlotOp, PlotData);
      else begin
        mon_e = exp_q.pop_front();
        if (PlotOp !== mon_e.op || PlotData !== mon_e.data)
          $display("FAIL cmd: got op=%0d data=%0d, want op=%0d data=%0d", PlotOp, PlotData, mon_e.op, mon_e.data);
        else n_pass++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic push(input logic [3:0] op, input logic [6:0] data);
    exp_t e;
    e.op = op;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    @(negedge Clock);
    while (PlotStart !== 1'b1 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    n_chk++;
    if (PlotStart !== 1'b1) $display("FAIL %s: PlotStart=%b after %0d cycles, want 1", name, PlotStart, n);
    else n_pass++;
  endtask

  task automatic send_done();
    @(negedge Clock);
    PlotDone = 1'b1;
    @(negedge Clock);
    PlotDone = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    cyc(3);
    n_chk++;
    if ({PlotStart, PlotOp, PlotData, Busy, Timeout} !== {1'b0, 4'd0, 7'd0, 1'b1, 1'b0})
      $display("FAIL reset_vals: start=%b op=%0d data=%0d busy=%b to=%b, want 0 0 0 1 0", PlotStart, PlotOp, PlotData, Busy, Timeout);
    else n_pass++;
    push(4'd1, 7'd0);
    Reset = 1'b1;
    wait_start("init_clear");
    cyc(1);
    n_chk++;
    if (Busy !== 1'b1) $display("FAIL init_busy: Busy=%b want 1", Busy);
    else n_pass++;
    PlotDone = 1'b1;
    cyc(1);
    PlotDone = 1'b0;
    n_chk++;
    if (Busy !== 1'b0) $display("FAIL init_idle: Busy=%b want 0", Busy);
    else n_pass++;
  endtask

  task automatic test_pitch_toggle();
    push(4'd6, 7'd0);
    PitchTurnedOn = 1'b1;
    cyc(1);
    PitchTurnedOn = 1'b0;
    cyc(1);
    n_chk++;
    if (PlotStart !== 1'b1) $display("FAIL toggle_latency: PlotStart=%b two cycles after pulse, want 1", PlotStart);
    else n_pass++;
    send_done();
    n_chk++;
    if (Busy !== 1'b0) $display("FAIL toggle_idle: Busy=%b want 0", Busy);
    else n_pass++;
  endtask

  task automatic test_level_rr();
    logic [6:0] d [2][3];
    d[0] = '{7'd20, 7'd40, 7'd60};
    d[1] = '{7'd1, 7'd2, 7'd3};
    for (int r = 0; r < 2; r++) begin
      push(4'd9, d[r][0]);
      push(4'd10, d[r][1]);
      push(4'd11, d[r][2]);
      {VolumeGo, PitchGo, DistortionGo} = 3'b111;
      {volume_data, pitch_data, distortion_data} = {d[r][0], d[r][1], d[r][2]};
      cyc(1);
      {VolumeGo, PitchGo, DistortionGo} = 3'b000;
      for (int k = 0; k < 3; k++) begin
        wait_start("level_rr");
        send_done();
      end
    end
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL level_rr_drain: %0d commands still expected, want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_coalesce();
    push(4'd2, 7'd0);
    VolumeTurnedOn = 1'b1;
    cyc(1);
    VolumeTurnedOn = 1'b0;
    wait_start("coalesce_first");
    cyc(1);
    VolumeGo = 1'b1;
    volume_data = 7'd5;
    cyc(1);
    volume_data = 7'd9;
    cyc(1);
    VolumeGo = 1'b0;
    PitchTurnedOff = 1'b1;
    cyc(1);
    PitchTurnedOff = 1'b0;
    volume_data = 7'd100;
    n_chk++;
    if (PlotOp !== 4'd2 || PlotData !== 7'd0) $display("FAIL snapshot: op=%0d data=%0d, want op=2 data=0", PlotOp, PlotData);
    else n_pass++;
    push(4'd7, 7'd0);
    push(4'd9, 7'd9);
    PlotDone = 1'b1;
    cyc(1);
    PlotDone = 1'b0;
    wait_start("coalesce_toggle");
    send_done();
    wait_start("coalesce_level");
    send_done();
    cyc(10);
    n_chk++;
    if (exp_q.size() != 0 || Busy !== 1'b0) $display("FAIL coalesce_drain: left=%0d Busy=%b, want 0 0", exp_q.size(), Busy);
    else n_pass++;
  endtask

  task automatic test_done_at_terminal();
    push(4'd4, 7'd0);
    DistortionTurnedOn = 1'b1;
    cyc(1);
    DistortionTurnedOn = 1'b0;
    wait_start("term_start");
    cyc(TO);
    n_chk++;
    if (Busy !== 1'b1) $display("FAIL term_wait: Busy=%b at terminal count, want 1", Busy);
    else n_pass++;
    PlotDone = 1'b1;
    cyc(1);
    PlotDone = 1'b0;
    n_chk++;
    if (Timeout !== 1'b0 || Busy !== 1'b0) $display("FAIL term_done: Timeout=%b Busy=%b, want 0 0", Timeout, Busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    push(4'd5, 7'd0);
    DistortionTurnedOff = 1'b1;
    cyc(1);
    DistortionTurnedOff = 1'b0;
    wait_start("to_start");
    cyc(1);
    push(4'd11, 7'd33);
    DistortionGo = 1'b1;
    distortion_data = 7'd33;
    cyc(1);
    DistortionGo = 1'b0;
    cyc(TO - 2);
    n_chk++;
    if (Timeout !== 1'b0 || Busy !== 1'b1) $display("FAIL to_early: Timeout=%b Busy=%b, want 0 1", Timeout, Busy);
    else n_pass++;
    cyc(1);
    n_chk++;
    if (Timeout !== 1'b1 || Busy !== 1'b0) $display("FAIL to_abort: Timeout=%b Busy=%b, want 1 0", Timeout, Busy);
    else n_pass++;
    PlotDone = 1'b1;
    cyc(2);
    PlotDone = 1'b0;
    n_chk++;
    if (Busy !== 1'b1 || exp_q.size() != 0) $display("FAIL to_late_done: Busy=%b left=%0d, want 1 0", Busy, exp_q.size());
    else n_pass++;
    cyc(2);
    n_chk++;
    if (Busy !== 1'b1) $display("FAIL to_rewait: Busy=%b want 1", Busy);
    else n_pass++;
    PlotDone = 1'b1;
    cyc(1);
    PlotDone = 1'b0;
    n_chk++;
    if (Busy !== 1'b0 || Timeout !== 1'b1) $display("FAIL to_sticky: Busy=%b Timeout=%b, want 0 1", Busy, Timeout);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    push(4'd3, 7'd0);
    VolumeTurnedOff = 1'b1;
    cyc(1);
    VolumeTurnedOff = 1'b0;
    wait_start("rst_start");
    cyc(1);
    PitchGo = 1'b1;
    pitch_data = 7'd7;
    PitchTurnedOn = 1'b1;
    cyc(1);
    PitchGo = 1'b0;
    PitchTurnedOn = 1'b0;
    Reset = 1'b0;
    #1;
    n_chk++;
    if ({PlotStart, PlotOp, PlotData, Busy, Timeout} !== {1'b0, 4'd0, 7'd0, 1'b1, 1'b0})
      $display("FAIL rst_async: start=%b op=%0d data=%0d busy=%b to=%b, want 0 0 0 1 0", PlotStart, PlotOp, PlotData, Busy, Timeout);
    else n_pass++;
    exp_q.delete();
    PlotReady = 1'b0;
    cyc(2);
    Reset = 1'b1;
    cyc(5);
    n_chk++;
    if (PlotStart !== 1'b0 || Busy !== 1'b1) $display("FAIL rst_not_ready: start=%b busy=%b, want 0 1", PlotStart, Busy);
    else n_pass++;
    push(4'd1, 7'd0);
    PlotReady = 1'b1;
    wait_start("rst_clear");
    send_done();
    cyc(10);
    n_chk++;
    if (exp_q.size() != 0 || Busy !== 1'b0) $display("FAIL rst_only_clear: left=%0d Busy=%b, want 0 0", exp_q.size(), Busy);
    else n_pass++;
  endtask

  initial begin
    {VolumeTurnedOn, VolumeTurnedOff, PitchTurnedOn, PitchTurnedOff} = '0;
    {DistortionTurnedOn, DistortionTurnedOff, VolumeGo, PitchGo, DistortionGo} = '0;
    {volume_data, pitch_data, distortion_data} = '0;
    PlotReady = 1'b1;
    PlotDone = 1'b0;
    test_reset();
    test_pitch_toggle();
    test_level_rr();
    test_coalesce();
    test_done_at_terminal();
    test_timeout();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
